// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, enable, wrap/saturate mode, event pulse and sticky ovf.
// Optional prescaler enabled by defining UPDOWN_COUNTER_PRESCALE_EN.
module updown_counter_param #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] LIMIT     = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             evt,
    output logic             ovf,
    output logic             at_zero,
    output logic             at_limit
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be 2..32");
    end
    if (LIMIT == '0) begin : g_bad_limit
        $error("updown_counter_param: LIMIT must be >= 1");
    end
    if (RESET_VAL > LIMIT) begin : g_bad_reset_val
        $error("updown_counter_param: RESET_VAL must be <= LIMIT");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("updown_counter_param: PRESCALE must be >= 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             evt_q, evt_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             boundary;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0] pre_q, pre_d;

    assign tick = (pre_q == PreLast);

    // Prescaler only advances on enabled cycles; load restarts the window.
    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign at_zero  = (count_q == '0);
    assign at_limit = (count_q == LIMIT);

    always_comb begin
        count_d  = count_q;
        boundary = 1'b0;
        if (load) begin
            count_d = (load_val > LIMIT) ? LIMIT : load_val;
        end else if (en && tick) begin
            if (up) begin
                if (at_limit) begin
                    boundary = 1'b1;
                    count_d  = sat ? LIMIT : '0;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    boundary = 1'b1;
                    count_d  = sat ? '0 : LIMIT;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
        evt_d = boundary;
        // Set beats clear when both happen in the same cycle.
        ovf_d = boundary ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RESET_VAL;
            evt_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            evt_q   <= evt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign evt   = evt_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three instances (LIMIT 15, LIMIT 9, prescaled) against a model.
module tb_updown_counter_param;

    localparam int LIM [3] = '{15, 9, 15};
    localparam int RV  [3] = '{0, 3, 0};
`ifdef UPDOWN_COUNTER_PRESCALE_EN
    localparam int PSE [3] = '{1, 1, 4};
`else
    localparam int PSE [3] = '{1, 1, 1};
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b0, sat = 1'b0, load = 1'b0, clr_ovf = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] cnt_w [3];
    logic       evt_w [3];
    logic       ovf_w [3];
    logic       zero_w [3];
    logic       lim_w [3];

    int total = 0;
    int bad   = 0;

    int m_cnt [3];
    int m_pre [3];
    bit m_evt [3];
    bit m_ovf [3];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .LIMIT(4'd15), .RESET_VAL(4'd0), .PRESCALE(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(cnt_w[0]), .evt(evt_w[0]), .ovf(ovf_w[0]),
        .at_zero(zero_w[0]), .at_limit(lim_w[0])
    );
    updown_counter_param #(.WIDTH(4), .LIMIT(4'd9), .RESET_VAL(4'd3), .PRESCALE(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(cnt_w[1]), .evt(evt_w[1]), .ovf(ovf_w[1]),
        .at_zero(zero_w[1]), .at_limit(lim_w[1])
    );
    updown_counter_param #(.WIDTH(4), .LIMIT(4'd15), .RESET_VAL(4'd0), .PRESCALE(4)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load), .load_val(load_val),
        .clr_ovf(clr_ovf), .count(cnt_w[2]), .evt(evt_w[2]), .ovf(ovf_w[2]),
        .at_zero(zero_w[2]), .at_limit(lim_w[2])
    );

    // Reference model: counts modulo LIMIT+1, boundary = attempted step past either end.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] <= RV[i];
                m_pre[i] <= 0;
                m_evt[i] <= 1'b0;
                m_ovf[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int c, nxt, pre;
                bit bnd;
                c   = m_cnt[i];
                nxt = c;
                pre = m_pre[i];
                bnd = 1'b0;
                if (load) begin
                    nxt = (int'(load_val) > LIM[i]) ? LIM[i] : int'(load_val);
                    pre = 0;
                end else if (en) begin
                    pre = pre + 1;
                    if (pre == PSE[i]) begin
                        pre = 0;
                        bnd = up ? (c == LIM[i]) : (c == 0);
                        if (!(bnd && sat)) begin
                            nxt = up ? (c + 1) % (LIM[i] + 1) : (c + LIM[i]) % (LIM[i] + 1);
                        end
                    end
                end
                m_cnt[i] <= nxt;
                m_pre[i] <= pre;
                m_evt[i] <= bnd;
                m_ovf[i] <= bnd ? 1'b1 : (clr_ovf ? 1'b0 : m_ovf[i]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.cnt%0d", tag, i), int'(cnt_w[i]), m_cnt[i]);
            chk($sformatf("%s.evt%0d", tag, i), int'(evt_w[i]), int'(m_evt[i]));
            chk($sformatf("%s.ovf%0d", tag, i), int'(ovf_w[i]), int'(m_ovf[i]));
            chk($sformatf("%s.zero%0d", tag, i), int'(zero_w[i]), int'(m_cnt[i] == 0));
            chk($sformatf("%s.lim%0d", tag, i), int'(lim_w[i]), int'(m_cnt[i] == LIM[i]));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input bit e, input bit u, input bit s, input bit l,
                          input logic [3:0] lv, input bit c);
        en = e; up = u; sat = s; load = l; load_val = lv; clr_ovf = c;
    endtask

    // Short reset pulse placed between edges.
    task automatic pulse_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    typedef struct {
        bit         en, up, sat, load;
        logic [3:0] lv;
        bit         clr;
        int         e_cnt;
        bit         e_evt, e_ovf;
    } vec_t;

    vec_t tbl [15];
    int   p_eff;

    initial begin
        // Table expectations are for instance u_b (LIMIT=9), starting from reset value 3.
        tbl[0]  = '{0, 0, 0, 1, 4'd7,  0, 7, 0, 0};
        tbl[1]  = '{1, 1, 1, 0, 4'd0,  0, 8, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 4'd0,  0, 9, 0, 0};
        tbl[3]  = '{1, 1, 1, 0, 4'd0,  0, 9, 1, 1};
        tbl[4]  = '{1, 1, 1, 0, 4'd0,  0, 9, 1, 1};
        tbl[5]  = '{1, 1, 1, 0, 4'd0,  0, 9, 1, 1};
        tbl[6]  = '{1, 1, 1, 1, 4'd12, 0, 9, 0, 1};
        tbl[7]  = '{1, 1, 0, 0, 4'd0,  0, 0, 1, 1};
        tbl[8]  = '{1, 0, 0, 0, 4'd0,  0, 9, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 4'd0,  0, 9, 0, 1};
        tbl[10] = '{1, 0, 1, 0, 4'd0,  0, 8, 0, 1};
        tbl[11] = '{1, 0, 1, 0, 4'd0,  1, 7, 0, 0};
        tbl[12] = '{0, 0, 0, 1, 4'd0,  0, 0, 0, 0};
        tbl[13] = '{1, 0, 1, 0, 4'd0,  1, 0, 1, 1};
        tbl[14] = '{0, 0, 0, 0, 4'd0,  1, 0, 0, 0};

        p_eff = PSE[2];

        #2 rst = 1'b0;
        #5;
        chk("rst_cnt_a", int'(cnt_w[0]), 0);
        chk("rst_cnt_b", int'(cnt_w[1]), 3);
        chk("rst_evt_b", int'(evt_w[1]), 0);
        chk("rst_ovf_a", int'(ovf_w[0]), 0);
        check_all("reset");
        #5 rst = 1'b1;
        @(posedge clk);
        #1;

        // Wrap-mode countdown from 0 on u_a.
        set_in(1, 0, 0, 0, 4'd0, 0);
        for (int k = 1; k <= 20; k++) begin
            step("down");
            chk($sformatf("down_cnt_a[%0d]", k), int'(cnt_w[0]), (16 - (k % 16)) % 16);
            chk($sformatf("down_evt_a[%0d]", k), int'(evt_w[0]), int'((k % 16) == 1));
        end
        chk("down_ovf_a", int'(ovf_w[0]), 1);

        // Table-driven sequence on u_b.
        pulse_reset();
        #1 check_all("tbl_rst");
        for (int i = 0; i < 15; i++) begin
            set_in(tbl[i].en, tbl[i].up, tbl[i].sat, tbl[i].load, tbl[i].lv, tbl[i].clr);
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt_w[1]), tbl[i].e_cnt);
            chk($sformatf("tbl%0d_evt", i), int'(evt_w[1]), int'(tbl[i].e_evt));
            chk($sformatf("tbl%0d_ovf", i), int'(ovf_w[1]), int'(tbl[i].e_ovf));
        end

        // Asynchronous reset in the middle of a countdown.
        set_in(0, 0, 0, 1, 4'd5, 0);
        step("ld5");
        set_in(1, 0, 0, 0, 4'd0, 0);
        step("dn4");
        step("dn3");
        #2 rst = 1'b0;
        #1;
        chk("arst_cnt_a", int'(cnt_w[0]), 0);
        chk("arst_cnt_b", int'(cnt_w[1]), 3);
        chk("arst_evt_a", int'(evt_w[0]), 0);
        chk("arst_ovf_a", int'(ovf_w[0]), 0);
        check_all("arst");
        #2 rst = 1'b1;

        // Prescaled up-count on u_c, including an en=0 gap.
        @(posedge clk);
        #1;
        pulse_reset();
        set_in(1, 1, 0, 0, 4'd0, 0);
        for (int k = 1; k <= 8; k++) step("ps");
        chk("ps_cnt_8", int'(cnt_w[2]), 8 / p_eff);
        step("ps");
        step("ps");
        en = 1'b0;
        step("ps_hold");
        step("ps_hold");
        en = 1'b1;
        step("ps");
        chk("ps_cnt_11", int'(cnt_w[2]), 11 / p_eff);
        step("ps");
        chk("ps_cnt_12", int'(cnt_w[2]), 12 / p_eff);

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            set_in(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 1) == 1, ($urandom_range(0, 9) == 0),
                   4'($urandom_range(0, 15)), ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
